// File: rtl/rgb_to_yuv_encoder_if.sv
// SRAM port bundle shared by the milestone engines.
// The master drives address, write data and the active-low write enable.
// The slave (the SRAM or its model) returns read data two edges after an
// address is registered.
interface rgb_to_yuv_encoder_if;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    output SRAM_address,
    output SRAM_write_data,
    output SRAM_we_n,
    input  SRAM_read_data
  );

  modport slave (
    input  SRAM_address,
    input  SRAM_write_data,
    input  SRAM_we_n,
    output SRAM_read_data
  );
endinterface

// File: rtl/rgb_to_yuv_encoder.sv
// RGB -> YUV (BT.601 integer) encoder with 2:1 horizontal chroma decimation.
// Works on groups of 4 pixels (6 packed RGB words in, 4 words out) in a
// fixed 16-cycle schedule: 6 address cycles, 2 read-latency cycles,
// 4 conversion cycles (one pixel each) and 4 write cycles.
// Build option: define ENC_UV_AVG_EN for rounding-average chroma decimation;
// without it the even pixel's chroma is kept and the odd pixel's is dropped.
module rgb_to_yuv_encoder #(
  parameter logic [17:0] Y_BASE     = 18'd0,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter int          NUM_PIXELS = 76800
) (
  input  logic                        Clock,
  input  logic                        Resetn,
  input  logic                        Enable,
  rgb_to_yuv_encoder_if.master        sram,
  output logic                        Done
);

  typedef enum logic [4:0] {
    S_IDLE,
    S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5,
    S_RDW0, S_RDW1,
    S_CONV0, S_CONV1, S_CONV2, S_CONV3,
    S_WR_Y0, S_WR_Y1, S_WR_U, S_WR_V,
    S_DONE
  } state_t;

  localparam logic [17:0] LAST_G = 18'(NUM_PIXELS / 4 - 1);

`ifdef ENC_UV_AVG_EN
  localparam int CHROMA_N = 4;
`else
  localparam int CHROMA_N = 2;
`endif

  state_t      state_q;
  logic [17:0] g_q;
  logic [15:0] w_q [0:5];
  logic [7:0]  y_q [0:3];
  logic [7:0]  u_q [0:CHROMA_N-1];
  logic [7:0]  v_q [0:CHROMA_N-1];

  logic [1:0]  conv_idx_s;
  logic [7:0]  pix_r_s, pix_g_s, pix_b_s;
  logic signed [17:0] rs_s, gs_s, bs_s;
  logic signed [17:0] y_sum_s, u_sum_s, v_sum_s;
  logic [7:0]  y_pix_s, u_pix_s, v_pix_s;
  logic [7:0]  ud01_s, ud23_s, vd01_s, vd23_s;
  logic [17:0] rgb_addr_s, y_addr_s, u_addr_s, v_addr_s;

`ifdef ENC_UV_AVG_EN
  // Rounding average of two chroma samples; 9-bit sum so 255+255+1 cannot wrap.
  function automatic logic [7:0] chroma_avg(input logic [7:0] even_c, input logic [7:0] odd_c);
    return 8'(({1'b0, even_c} + {1'b0, odd_c} + 9'd1) >> 4'd1);
  endfunction

  assign ud01_s = chroma_avg(u_q[0], u_q[1]);
  assign ud23_s = chroma_avg(u_q[2], u_q[3]);
  assign vd01_s = chroma_avg(v_q[0], v_q[1]);
  assign vd23_s = chroma_avg(v_q[2], v_q[3]);
`else
  assign ud01_s = u_q[0];
  assign ud23_s = u_q[1];
  assign vd01_s = v_q[0];
  assign vd23_s = v_q[1];
`endif

  assign rgb_addr_s = RGB_BASE + (g_q * 18'd6);
  assign y_addr_s   = Y_BASE + (g_q * 18'd2);
  assign u_addr_s   = U_BASE + g_q;
  assign v_addr_s   = V_BASE + g_q;

  // Pixel index being converted, derived from the conversion state.
  always_comb begin
    conv_idx_s = 2'd0;
    case (state_q)
      S_CONV1: conv_idx_s = 2'd1;
      S_CONV2: conv_idx_s = 2'd2;
      S_CONV3: conv_idx_s = 2'd3;
      default: conv_idx_s = 2'd0;
    endcase
  end

  // Unpack R, G, B of the selected pixel from the six captured words.
  always_comb begin
    pix_r_s = 8'd0;
    pix_g_s = 8'd0;
    pix_b_s = 8'd0;
    case (conv_idx_s)
      2'd0: begin pix_r_s = w_q[0][15:8]; pix_g_s = w_q[0][7:0];  pix_b_s = w_q[1][15:8]; end
      2'd1: begin pix_r_s = w_q[1][7:0];  pix_g_s = w_q[2][15:8]; pix_b_s = w_q[2][7:0];  end
      2'd2: begin pix_r_s = w_q[3][15:8]; pix_g_s = w_q[3][7:0];  pix_b_s = w_q[4][15:8]; end
      2'd3: begin pix_r_s = w_q[4][7:0];  pix_g_s = w_q[5][15:8]; pix_b_s = w_q[5][7:0];  end
      default: begin pix_r_s = 8'd0; pix_g_s = 8'd0; pix_b_s = 8'd0; end
    endcase
  end

  // Signed colour-space arithmetic; the floor shift matters for negative U/V sums.
  assign rs_s    = signed'({10'd0, pix_r_s});
  assign gs_s    = signed'({10'd0, pix_g_s});
  assign bs_s    = signed'({10'd0, pix_b_s});
  assign y_sum_s = 18'sd66 * rs_s + 18'sd129 * gs_s + 18'sd25 * bs_s + 18'sd128;
  assign u_sum_s = 18'sd128 - 18'sd38 * rs_s - 18'sd74 * gs_s + 18'sd112 * bs_s;
  assign v_sum_s = 18'sd128 + 18'sd112 * rs_s - 18'sd94 * gs_s - 18'sd18 * bs_s;
  assign y_pix_s = 8'((y_sum_s >>> 4'd8) + 18'sd16);
  assign u_pix_s = 8'((u_sum_s >>> 4'd8) + 18'sd128);
  assign v_pix_s = 8'((v_sum_s >>> 4'd8) + 18'sd128);

  // Main sequencer: drives the SRAM port, captures reads and holds results.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q              <= S_IDLE;
      g_q                  <= 18'd0;
      sram.SRAM_address    <= 18'd0;
      sram.SRAM_write_data <= 16'd0;
      sram.SRAM_we_n       <= 1'b1;
      Done                 <= 1'b0;
      for (int i = 0; i < 6; i++) w_q[i] <= 16'd0;
      for (int i = 0; i < 4; i++) y_q[i] <= 8'd0;
      for (int i = 0; i < CHROMA_N; i++) begin
        u_q[i] <= 8'd0;
        v_q[i] <= 8'd0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          sram.SRAM_we_n <= 1'b1;
          Done           <= 1'b0;
          g_q            <= 18'd0;
          if (Enable) state_q <= S_RD0;
        end
        S_RD0: begin
          sram.SRAM_address <= rgb_addr_s;
          sram.SRAM_we_n    <= 1'b1;
          state_q           <= S_RD1;
        end
        S_RD1: begin
          sram.SRAM_address <= rgb_addr_s + 18'd1;
          state_q           <= S_RD2;
        end
        S_RD2: begin
          sram.SRAM_address <= rgb_addr_s + 18'd2;
          w_q[0]            <= sram.SRAM_read_data;
          state_q           <= S_RD3;
        end
        S_RD3: begin
          sram.SRAM_address <= rgb_addr_s + 18'd3;
          w_q[1]            <= sram.SRAM_read_data;
          state_q           <= S_RD4;
        end
        S_RD4: begin
          sram.SRAM_address <= rgb_addr_s + 18'd4;
          w_q[2]            <= sram.SRAM_read_data;
          state_q           <= S_RD5;
        end
        S_RD5: begin
          sram.SRAM_address <= rgb_addr_s + 18'd5;
          w_q[3]            <= sram.SRAM_read_data;
          state_q           <= S_RDW0;
        end
        S_RDW0: begin
          w_q[4]  <= sram.SRAM_read_data;
          state_q <= S_RDW1;
        end
        S_RDW1: begin
          w_q[5]  <= sram.SRAM_read_data;
          state_q <= S_CONV0;
        end
        S_CONV0, S_CONV1, S_CONV2, S_CONV3: begin
          y_q[conv_idx_s] <= y_pix_s;
`ifdef ENC_UV_AVG_EN
          u_q[conv_idx_s] <= u_pix_s;
          v_q[conv_idx_s] <= v_pix_s;
`else
          if (!conv_idx_s[0]) begin
            u_q[conv_idx_s[1]] <= u_pix_s;
            v_q[conv_idx_s[1]] <= v_pix_s;
          end
`endif
          if (state_q == S_CONV3) state_q <= S_WR_Y0;
          else                    state_q <= state_t'(state_q + 5'd1);
        end
        S_WR_Y0: begin
          sram.SRAM_address    <= y_addr_s;
          sram.SRAM_write_data <= {y_q[0], y_q[1]};
          sram.SRAM_we_n       <= 1'b0;
          state_q              <= S_WR_Y1;
        end
        S_WR_Y1: begin
          sram.SRAM_address    <= y_addr_s + 18'd1;
          sram.SRAM_write_data <= {y_q[2], y_q[3]};
          sram.SRAM_we_n       <= 1'b0;
          state_q              <= S_WR_U;
        end
        S_WR_U: begin
          sram.SRAM_address    <= u_addr_s;
          sram.SRAM_write_data <= {ud01_s, ud23_s};
          sram.SRAM_we_n       <= 1'b0;
          state_q              <= S_WR_V;
        end
        S_WR_V: begin
          sram.SRAM_address    <= v_addr_s;
          sram.SRAM_write_data <= {vd01_s, vd23_s};
          sram.SRAM_we_n       <= 1'b0;
          if (g_q == LAST_G) begin
            Done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            g_q     <= g_q + 18'd1;
            state_q <= S_RD0;
          end
        end
        S_DONE: begin
          sram.SRAM_we_n <= 1'b1;
          if (!Enable) begin
            Done    <= 1'b0;
            g_q     <= 18'd0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          sram.SRAM_we_n <= 1'b1;
          Done           <= 1'b0;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
